// File: rtl/imem_arbiter_pkg.sv
// Shared types for the instruction-fetch arbiter and its round-robin picker.
package imem_arbiter_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic {
    IA_IDLE  = 1'b0,
    IA_FETCH = 1'b1
  } iarb_state_t;

  // Index width for an n-way requester vector; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/imem_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request after the last winner.
module rr_pick
  import imem_arbiter_pkg::*;
#(
  parameter int CPUS  = 2,
  parameter int IDX_W = idx_w(CPUS)
) (
  input  logic [CPUS-1:0]  req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [IDX_W-1:0] grant_o,
  output logic             valid_o
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    idx     = '0;
    // Start one past the previous winner so the last-served core has lowest priority.
    for (int k = 1; k <= CPUS; k++) begin
      idx = IDX_W'((int'(last_i) + k) % CPUS);
      if (!valid_o && req_i[idx]) begin
        valid_o = 1'b1;
        grant_o = idx;
      end
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Memory-side responder for per-core icache fetches sharing one RAM read port.
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int CPUS = 2
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [CPUS-1:0]      iREN,
  input  word_t [CPUS-1:0]     iaddr,
  output logic [CPUS-1:0]      iwait,
  output word_t [CPUS-1:0]     iload,
  input  logic                 dbusy,
  output logic                 ramREN,
  output word_t                ramaddr,
  input  word_t                ramload,
  input  ramstate_t            ramstate
);

  localparam int IDX_W = idx_w(CPUS);

  iarb_state_t      state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] last_q,  last_d;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_vld;

  rr_pick #(
    .CPUS  (CPUS),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i   (iREN),
    .last_i  (last_q),
    .grant_o (pick_idx),
    .valid_o (pick_vld)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IA_IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(CPUS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    ramREN  = 1'b0;
    ramaddr = '0;
    iwait   = '1;
    iload   = '0;
    case (state_q)
      IA_IDLE: begin
        // Data traffic only blocks the start of a fetch, never one in flight.
        if (!dbusy && pick_vld) begin
          grant_d = pick_idx;
          state_d = IA_FETCH;
        end
      end
      IA_FETCH: begin
        ramREN  = 1'b1;
        ramaddr = iaddr[grant_q];
        // A withdrawn request wins over a coincident ACCESS: nothing is released.
        if (!iREN[grant_q]) begin
          state_d = IA_IDLE;
        end else if (ramstate == ACCESS) begin
          iwait[grant_q] = 1'b0;
          iload[grant_q] = ramload;
          last_d         = grant_q;
          state_d        = IA_IDLE;
        end
      end
      default: state_d = IA_IDLE;
    endcase
  end

endmodule
